// File: rtl/logic_ramp_driver.sv
// rtl/logic_ramp_driver.sv - slew-limited DAC code driver with transport delay and thl/thh receiver view
// Optional reversal counter/pulse outputs enabled by defining LOGIC_RAMP_GLITCH_EN.
module logic_ramp_driver #(
    parameter int W         = 8,
    parameter int DELAY     = 4,
    parameter int RISE_STEP = 32,
    parameter int FALL_STEP = 32,
    parameter int THH       = 230,
    parameter int THL       = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] v,
    output logic         q,
    output logic         x,
    output logic         busy
`ifdef LOGIC_RAMP_GLITCH_EN
    ,
    output logic         glitch,
    output logic [7:0]   glitch_cnt
`endif
);

    typedef enum logic [1:0] {IDLE_LO, RISING, IDLE_HI, FALLING} state_t;

    localparam logic [W:0]   VMAX_X = {1'b0, {W{1'b1}}};
    localparam logic [W:0]   RSTEP  = (W+1)'(RISE_STEP);
    localparam logic [W:0]   FSTEP  = (W+1)'(FALL_STEP);
    localparam logic [W-1:0] THH_C  = W'(THH);
    localparam logic [W-1:0] THL_C  = W'(THL);

    state_t         state;
    state_t         nstate;
    logic [DELAY:0] dline;
    logic           dly;
    logic [W:0]     up;
    logic [W-1:0]   up_sat;
    logic [W-1:0]   dn_sat;
    logic [W-1:0]   nv;
    logic           nq;
    logic           nx;
    logic           rev;

    // Stage 0 captures d on the sampling edge, so dly shows it after edge DELAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dline <= '0;
        end else begin
            dline <= {dline[DELAY-1:0], d};
        end
    end

    assign dly    = dline[DELAY];
    assign up     = {1'b0, v} + RSTEP;
    assign up_sat = (up > VMAX_X) ? {W{1'b1}} : up[W-1:0];
    assign dn_sat = ({1'b0, v} <= FSTEP) ? '0 : (v - FSTEP[W-1:0]);

    always_comb begin
        nv     = v;
        nstate = state;
        rev    = 1'b0;
        case (state)
            IDLE_LO: begin
                if (dly) begin
                    nv     = up_sat;
                    nstate = (up_sat == {W{1'b1}}) ? IDLE_HI : RISING;
                end
            end
            RISING: begin
                if (dly) begin
                    nv     = up_sat;
                    nstate = (up_sat == {W{1'b1}}) ? IDLE_HI : RISING;
                end else begin
                    nv     = dn_sat;
                    nstate = (dn_sat == '0) ? IDLE_LO : FALLING;
                    rev    = 1'b1;
                end
            end
            IDLE_HI: begin
                if (!dly) begin
                    nv     = dn_sat;
                    nstate = (dn_sat == '0) ? IDLE_LO : FALLING;
                end
            end
            FALLING: begin
                if (!dly) begin
                    nv     = dn_sat;
                    nstate = (dn_sat == '0) ? IDLE_LO : FALLING;
                end else begin
                    nv     = up_sat;
                    nstate = (up_sat == {W{1'b1}}) ? IDLE_HI : RISING;
                    rev    = 1'b1;
                end
            end
            default: begin
                nv     = '0;
                nstate = IDLE_LO;
            end
        endcase
    end

    // Receiver view uses next-v so q/x line up with the v they describe.
    always_comb begin
        nq = q;
        if (nv >= THH_C) begin
            nq = 1'b1;
        end else if (nv <= THL_C) begin
            nq = 1'b0;
        end
        nx = (nv > THL_C) && (nv < THH_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_LO;
            v     <= '0;
            q     <= 1'b0;
            x     <= 1'b0;
            busy  <= 1'b0;
        end else if (en) begin
            state <= nstate;
            v     <= nv;
            q     <= nq;
            x     <= nx;
            busy  <= (nstate == RISING) || (nstate == FALLING);
        end
    end

`ifdef LOGIC_RAMP_GLITCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            glitch <= en && rev;
            if (en && rev && (glitch_cnt != 8'hFF)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
